// File: rtl/disp_pkg.sv
// Shared types, glyph constants and helpers for the multiplexed 7-segment scan driver.
// Glyphs are active-low with CA..CG on bits 6..0.
package disp_pkg;

  localparam int unsigned N_DIG_DEFAULT = 8;
  localparam int unsigned N_DIG_MAX     = 32;

  localparam logic [6:0] GLYPH_BLANK = 7'h7F;
  localparam logic [6:0] GLYPH_0     = 7'b0000001;
  localparam logic [6:0] GLYPH_1     = 7'b1001111;
  localparam logic [6:0] GLYPH_2     = 7'b0010010;
  localparam logic [6:0] GLYPH_3     = 7'b0000110;
  localparam logic [6:0] GLYPH_4     = 7'b1001100;
  localparam logic [6:0] GLYPH_5     = 7'b0100100;
  localparam logic [6:0] GLYPH_6     = 7'b0100000;
  localparam logic [6:0] GLYPH_7     = 7'b0001111;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0000100;
  localparam logic [6:0] GLYPH_A     = 7'b0001000;

  typedef enum logic [0:0] {
    StBlank,
    StDrive
  } disp_state_e;

  // Active-low anode vector with only bit idx cleared; callers size-cast to their digit count.
  function automatic logic [N_DIG_MAX-1:0] onehot_low(input int unsigned idx);
    return ~(N_DIG_MAX'(1) << idx);
  endfunction

endpackage

// File: rtl/fase_timer.sv
// Phase duration counter: counts up from zero, flags done at the limit, and clears on request.
module fase_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic [Width-1:0] limit_i,
  output logic [Width-1:0] count_o,
  output logic             done_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clear_i ? '0 : cnt_q + Width'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign done_o  = (cnt_q == limit_i);

endmodule

// File: rtl/escaneo_display.sv
// Time-multiplexed scan driver for a common-anode 7-segment display with blanking gaps
// and a shadow register that commits new patterns only at frame boundaries.
module escaneo_display
  import disp_pkg::*;
#(
  parameter int unsigned N_DIG        = N_DIG_DEFAULT,
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7*N_DIG-1:0] seg_in,
  input  logic [N_DIG-1:0]   mask_in,
  input  logic               load_valid,
  output logic               load_ready,
  output logic               frame_tick,
  output logic [6:0]         segmentos,
  output logic [N_DIG-1:0]   anodos
);

  localparam int unsigned CntMax = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned IdxW   = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_DIG - 1);

  disp_state_e state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;

  logic [N_DIG-1:0][6:0] pend_seg_q, pend_seg_d;
  logic [N_DIG-1:0][6:0] act_seg_q, act_seg_d;
  logic [N_DIG-1:0]      pend_mask_q, pend_mask_d;
  logic [N_DIG-1:0]      act_mask_q, act_mask_d;
  logic                  pend_full_q, pend_full_d;

  logic             load_ready_q, load_ready_d;
  logic             frame_tick_q, frame_tick_d;
  logic [6:0]       seg_q, seg_d;
  logic [N_DIG-1:0] an_q, an_d;

  logic [CntW-1:0] cnt;
  logic [CntW-1:0] limit;
  logic            phase_done;
  logic            frame_end;
  logic            accept;

  assign limit = (state_q == StBlank) ? CntW'(BLANK_CYCLES - 1) : CntW'(DIGIT_CYCLES - 1);

  // The counter restarts on every phase change, so done doubles as its clear.
  fase_timer #(
    .Width(CntW)
  ) u_timer (
    .clk_i  (clk),
    .rst_i  (rst),
    .clear_i(phase_done),
    .limit_i(limit),
    .count_o(cnt),
    .done_o (phase_done)
  );

  assign frame_end = phase_done && (state_q == StDrive) && (idx_q == LastIdx);
  assign accept    = load_valid && load_ready_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (phase_done) begin
      if (state_q == StBlank) begin
        state_d = StDrive;
      end else begin
        state_d = StBlank;
        idx_d   = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
      end
    end
  end

  // Accept and commit are mutually exclusive: accept needs an empty shadow, commit a full one.
  always_comb begin
    pend_seg_d  = pend_seg_q;
    pend_mask_d = pend_mask_q;
    pend_full_d = pend_full_q;
    act_seg_d   = act_seg_q;
    act_mask_d  = act_mask_q;
    if (accept) begin
      pend_seg_d  = seg_in;
      pend_mask_d = mask_in;
      pend_full_d = 1'b1;
    end else if (frame_end && pend_full_q) begin
      act_seg_d   = pend_seg_q;
      act_mask_d  = pend_mask_q;
      pend_full_d = 1'b0;
    end
    load_ready_d = !pend_full_d;
  end

  // Outputs follow the current phase one cycle later, so anodes and segments move together.
  always_comb begin
    frame_tick_d = (state_q == StBlank) && (idx_q == '0) && (cnt == '0);
    an_d         = '1;
    seg_d        = GLYPH_BLANK;
    if (state_q == StDrive) begin
      an_d = N_DIG'(onehot_low(32'(idx_q)));
      if (act_mask_q[idx_q]) begin
        seg_d = act_seg_q[idx_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StBlank;
      idx_q        <= '0;
      pend_seg_q   <= '1;
      pend_mask_q  <= '0;
      pend_full_q  <= 1'b0;
      act_seg_q    <= {N_DIG{GLYPH_BLANK}};
      act_mask_q   <= '0;
      load_ready_q <= 1'b1;
      frame_tick_q <= 1'b0;
      seg_q        <= GLYPH_BLANK;
      an_q         <= '1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pend_seg_q   <= pend_seg_d;
      pend_mask_q  <= pend_mask_d;
      pend_full_q  <= pend_full_d;
      act_seg_q    <= act_seg_d;
      act_mask_q   <= act_mask_d;
      load_ready_q <= load_ready_d;
      frame_tick_q <= frame_tick_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign load_ready = load_ready_q;
  assign frame_tick = frame_tick_q;
  assign segmentos  = seg_q;
  assign anodos     = an_q;

endmodule

// File: tb/tb_escaneo_display.sv
// Bench for escaneo_display: frame-position reference model checked every cycle, a table of
// pattern/mask vectors, hand-written handshake corner cases and a randomized soak.
module tb_escaneo_display;
  import disp_pkg::*;

  localparam int NDig   = 8;
  localparam int DigCyc = 4;
  localparam int BlkCyc = 2;
  localparam int Period = DigCyc + BlkCyc;
  localparam int Frame  = NDig * Period;

  logic                clk = 1'b0;
  logic                rst;
  logic [7*NDig-1:0]   seg_in;
  logic [NDig-1:0]     mask_in;
  logic                load_valid;
  logic                load_ready;
  logic                frame_tick;
  logic [6:0]          segmentos;
  logic [NDig-1:0]     anodos;

  always #5 clk = ~clk;

  escaneo_display #(
    .N_DIG       (NDig),
    .DIGIT_CYCLES(DigCyc),
    .BLANK_CYCLES(BlkCyc)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_in    (seg_in),
    .mask_in   (mask_in),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .frame_tick(frame_tick),
    .segmentos (segmentos),
    .anodos    (anodos)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: m_t is the frame position whose outputs appear after the next edge.
  int                    m_t = 0;
  bit                    m_full = 1'b0;
  logic [NDig-1:0][6:0]  m_pseg, m_aseg;
  logic [NDig-1:0]       m_pmask, m_amask;
  logic [NDig-1:0]       e_an = '1;
  logic [6:0]            e_seg = GLYPH_BLANK;
  logic                  e_tick = 1'b0;
  logic                  e_ready = 1'b1;

  logic [NDig-1:0] prev_an = '1;
  logic [6:0]      prev_seg = GLYPH_BLANK;
  int              cyc = 0;
  int              last_tick = -1;

  typedef struct {
    logic [7*NDig-1:0] seg;
    logic [NDig-1:0]   mask;
    logic [7*NDig-1:0] exp_drive;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  d, w;
    bit  accept, commit;
    if (rst) begin
      e_an = '1; e_seg = GLYPH_BLANK; e_tick = 1'b0; e_ready = 1'b1;
      m_t = 0; m_full = 1'b0; m_amask = '0; m_aseg = {NDig{GLYPH_BLANK}};
    end else begin
      d = m_t / Period;
      w = m_t % Period;
      e_tick = (m_t == 0);
      e_an   = '1;
      e_seg  = GLYPH_BLANK;
      if (w >= BlkCyc) begin
        e_an[d] = 1'b0;
        if (m_amask[d]) e_seg = m_aseg[d];
      end
      commit = (m_t == Frame - 1) && m_full;
      accept = load_valid && e_ready;
      if (commit) begin
        m_aseg = m_pseg; m_amask = m_pmask; m_full = 1'b0;
      end
      if (accept) begin
        m_pseg = seg_in; m_pmask = mask_in; m_full = 1'b1;
      end
      e_ready = !m_full;
      m_t = (m_t + 1) % Frame;
    end
  endtask

  task automatic step();
    bit rst_at_edge;
    @(posedge clk);
    rst_at_edge = rst;
    model_edge();
    #1;
    cyc++;
    chk("anodos", 64'(anodos), 64'(e_an));
    chk("segmentos", 64'(segmentos), 64'(e_seg));
    chk("frame_tick", 64'(frame_tick), 64'(e_tick));
    chk("load_ready", 64'(load_ready), 64'(e_ready));
    chk("one_anode_low", 64'($countones(~anodos) <= 1), 64'(1));
    if (prev_an != '1 && anodos == prev_an) chk("seg_stable_while_lit", 64'(segmentos),
                                                64'(prev_seg));
    if (anodos != '1 && anodos != prev_an) chk("anode_low_only_from_dark", 64'(prev_an),
                                               64'({NDig{1'b1}}));
    if (rst_at_edge) begin
      last_tick = -1;
    end else if (frame_tick) begin
      if (last_tick >= 0) chk("tick_spacing", 64'(cyc - last_tick), 64'(Frame));
      last_tick = cyc;
    end
    prev_an  = anodos;
    prev_seg = segmentos;
  endtask

  task automatic wait_mt(input int target);
    int guard = 0;
    while (m_t != target && guard < 2 * Frame) begin
      step();
      guard++;
    end
    chk("wait_bound", 64'(m_t == target), 64'(1));
  endtask

  task automatic load(input logic [7*NDig-1:0] s, input logic [NDig-1:0] m);
    int guard = 0;
    bit took  = 1'b0;
    seg_in = s; mask_in = m; load_valid = 1'b1;
    while (!took && guard < 3 * Frame) begin
      took = load_ready;
      step();
      guard++;
    end
    chk("load_accept_bound", 64'(took), 64'(1));
    load_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NDig-1:0] exp_an;
    rst = 1'b1; load_valid = 1'b0; seg_in = '0; mask_in = '0;

    vecs[0] = '{{NDig{GLYPH_A}}, 8'hFF, {NDig{GLYPH_A}}};
    vecs[1] = '{{NDig{GLYPH_A}}, 8'b0000_0100,
                {{5{GLYPH_BLANK}}, GLYPH_A, {2{GLYPH_BLANK}}}};
    vecs[2] = '{{GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0}, 8'hF0,
                {GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, {4{GLYPH_BLANK}}}};
    vecs[3] = '{{NDig{GLYPH_8}}, 8'h00, {NDig{GLYPH_BLANK}}};

    step(); step();
    rst = 1'b0;

    // Reset held mid-drive of digit 5, then restart timing.
    wait_mt(5 * Period + BlkCyc);
    step(); step();
    chk("mid_drive_digit5", 64'(anodos), 64'(8'hDF));
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_anodos", 64'(anodos), 64'(8'hFF));
      chk("rst_segmentos", 64'(segmentos), 64'(7'h7F));
    end
    rst = 1'b0;
    step();
    chk("tick_after_release", 64'(frame_tick), 64'(1));
    step();
    chk("blank_after_release", 64'(anodos), 64'(8'hFF));
    step();
    chk("digit0_lit", 64'(anodos), 64'(8'hFE));

    // Table: load, let it commit, then walk the whole next frame.
    for (int v = 0; v < 4; v++) begin
      load(vecs[v].seg, vecs[v].mask);
      wait_mt(Frame - 1);
      step();
      for (int d = 0; d < NDig; d++) begin
        for (int w = 0; w < Period; w++) begin
          step();
          if (w < BlkCyc) begin
            chk("tbl_blank_an", 64'(anodos), 64'(8'hFF));
            chk("tbl_blank_seg", 64'(segmentos), 64'(7'h7F));
          end else begin
            exp_an = ~(8'h01 << d);
            chk("tbl_drive_an", 64'(anodos), 64'(exp_an));
            chk("tbl_drive_seg", 64'(segmentos), 64'(vecs[v].exp_drive[7*d +: 7]));
          end
        end
      end
    end

    // Back-to-back loads: second waits for the commit, shows one frame later.
    load({NDig{GLYPH_1}}, 8'hFF);
    seg_in = {NDig{GLYPH_2}}; mask_in = 8'hFF; load_valid = 1'b1;
    chk("ready_low_while_pending", 64'(load_ready), 64'(0));
    wait_mt(Frame - 1);
    step();
    chk("ready_after_commit", 64'(load_ready), 64'(1));
    step();
    load_valid = 1'b0;
    chk("ready_low_second_load", 64'(load_ready), 64'(0));
    step(); step();
    chk("first_load_shown", 64'(segmentos), 64'(GLYPH_1));
    wait_mt(Frame - 1);
    for (int i = 0; i < 4; i++) step();
    chk("second_load_shown", 64'(segmentos), 64'(GLYPH_2));

    // Load landing exactly on the commit edge with an empty shadow.
    wait_mt(Frame - 1);
    seg_in = {NDig{GLYPH_3}}; mask_in = 8'hFF; load_valid = 1'b1;
    chk("ready_at_commit_edge", 64'(load_ready), 64'(1));
    step();
    load_valid = 1'b0;
    step(); step(); step();
    chk("late_load_not_next_frame", 64'(segmentos), 64'(GLYPH_2));
    wait_mt(Frame - 1);
    for (int i = 0; i < 4; i++) step();
    chk("late_load_frame_after", 64'(segmentos), 64'(GLYPH_3));

    // Randomized soak over 10 frames; source holds data until accepted.
    for (int c = 0; c < 10 * Frame; c++) begin
      bit fire;
      if (!load_valid && $urandom_range(0, 19) == 0) begin
        seg_in     = 56'({$urandom(), $urandom()});
        mask_in    = 8'($urandom());
        load_valid = 1'b1;
      end
      fire = load_valid && load_ready;
      step();
      if (fire) load_valid = 1'b0;
    end
    load_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
